// File: rtl/kbd_seg_led_panel.sv
// kbd_seg_led_panel: PS/2 keyboard receiver with make/break tracking, eight
// active-low 7-segment digits and a 16-bit LED bank (switch mirror plus a
// rotating one-hot light).
// Optional feature macro: PS2_ERRCNT_EN. When defined, an 8-bit error counter
// of bad frames and timeouts is shown on seg7:seg6 instead of the switches.
module kbd_seg_led_panel #(
    parameter int LED_DIV     = 5000000,
    parameter int PS2_TIMEOUT = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  btn,
    input  logic [7:0]  sw,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] ledr,
    output logic [7:0]  seg0,
    output logic [7:0]  seg1,
    output logic [7:0]  seg2,
    output logic [7:0]  seg3,
    output logic [7:0]  seg4,
    output logic [7:0]  seg5,
    output logic [7:0]  seg6,
    output logic [7:0]  seg7
);

    localparam int DIV_W = $clog2(LED_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(LED_DIV - 1);
    localparam int TO_W = $clog2(PS2_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(PS2_TIMEOUT - 1);

    // Active-low hex font, bit7=a .. bit1=g, bit0=dp (always off).
    function automatic logic [7:0] hex_font(input logic [3:0] nib);
        case (nib)
            4'h0: hex_font = 8'h03;
            4'h1: hex_font = 8'h9F;
            4'h2: hex_font = 8'h25;
            4'h3: hex_font = 8'h0D;
            4'h4: hex_font = 8'h99;
            4'h5: hex_font = 8'h49;
            4'h6: hex_font = 8'h41;
            4'h7: hex_font = 8'h1F;
            4'h8: hex_font = 8'h01;
            4'h9: hex_font = 8'h09;
            4'hA: hex_font = 8'h11;
            4'hB: hex_font = 8'hC1;
            4'hC: hex_font = 8'h63;
            4'hD: hex_font = 8'h85;
            4'hE: hex_font = 8'h61;
            default: hex_font = 8'h71;
        endcase
    endfunction

    // btn[4:2] have no function on this panel.
    logic unused_btn;
    assign unused_btn = ^btn[4:2];

    // ---------------- PS/2 receiver ----------------
    logic [2:0]      ps2_clk_sync_reg;
    logic [1:0]      ps2_data_sync_reg;
    logic [3:0]      bit_cnt_reg;
    logic [9:0]      shift_reg;
    logic [TO_W-1:0] to_cnt_reg;
    logic            code_valid_reg;
    logic [7:0]      code_reg;

    logic        fall_edge;
    logic        data_bit;
    logic [10:0] frame;
    logic        frame_ok;

    assign fall_edge = ps2_clk_sync_reg[2] & ~ps2_clk_sync_reg[1];
    assign data_bit  = ps2_data_sync_reg[1];
    // On the 11th edge the frame is the ten stored bits plus the one being sampled.
    assign frame     = {data_bit, shift_reg};
    assign frame_ok  = ~frame[0] & frame[10] & (^frame[9:1]);

    // Bring the asynchronous PS/2 lines into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps2_clk_sync_reg  <= '0;
            ps2_data_sync_reg <= '0;
        end else begin
            ps2_clk_sync_reg  <= {ps2_clk_sync_reg[1:0], ps2_clk};
            ps2_data_sync_reg <= {ps2_data_sync_reg[0], ps2_data};
        end
    end

    // Shift in frame bits on ps2_clk falling edges; drop stalled partial frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            to_cnt_reg     <= '0;
            code_valid_reg <= 1'b0;
            code_reg       <= '0;
        end else begin
            code_valid_reg <= 1'b0;
            if (fall_edge) begin
                to_cnt_reg <= '0;
                if (bit_cnt_reg == 4'd10) begin
                    bit_cnt_reg <= '0;
                    if (frame_ok) begin
                        code_valid_reg <= 1'b1;
                        code_reg       <= frame[8:1];
                    end
                end else begin
                    shift_reg   <= {data_bit, shift_reg[9:1]};
                    bit_cnt_reg <= bit_cnt_reg + 4'd1;
                end
            end else if (bit_cnt_reg != 4'd0) begin
                if (to_cnt_reg == TO_MAX) begin
                    bit_cnt_reg <= '0;
                    to_cnt_reg  <= '0;
                end else begin
                    to_cnt_reg <= to_cnt_reg + 1'b1;
                end
            end else begin
                to_cnt_reg <= '0;
            end
        end
    end

    // ---------------- Key tracking ----------------
    logic       brk_reg;
    logic       held_reg;
    logic [7:0] cur_reg;
    logic [7:0] last_reg;
    logic [7:0] press_cnt_reg;
    logic       is_make;
    logic       count_make;

    assign is_make    = code_valid_reg && (code_reg != 8'hE0) && (code_reg != 8'hF0) && !brk_reg;
    // Typematic repeats of the held key are not new presses.
    assign count_make = is_make && (!held_reg || (code_reg != cur_reg));

    // Interpret accepted codes as prefix, break marker, release or make.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            brk_reg  <= 1'b0;
            held_reg <= 1'b0;
            cur_reg  <= '0;
            last_reg <= '0;
        end else if (code_valid_reg && (code_reg != 8'hE0)) begin
            if (code_reg == 8'hF0) begin
                brk_reg <= 1'b1;
            end else if (brk_reg) begin
                held_reg <= 1'b0;
                brk_reg  <= 1'b0;
                last_reg <= code_reg;
            end else begin
                cur_reg  <= code_reg;
                last_reg <= code_reg;
                held_reg <= 1'b1;
            end
        end
    end

    // Press counter; the clear button takes priority over a coincident make.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_cnt_reg <= '0;
        end else if (btn[1]) begin
            press_cnt_reg <= '0;
        end else if (count_make) begin
            press_cnt_reg <= press_cnt_reg + 8'd1;
        end
    end

    // Value shown on the leftmost digit pair.
    logic [7:0] top_pair;

`ifdef PS2_ERRCNT_EN
    logic [7:0] err_cnt_reg;
    logic       frame_bad;
    logic       timeout_hit;

    assign frame_bad   = fall_edge && (bit_cnt_reg == 4'd10) && !frame_ok;
    assign timeout_hit = !fall_edge && (bit_cnt_reg != 4'd0) && (to_cnt_reg == TO_MAX);

    // Count discarded frames, both malformed and timed out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_reg <= '0;
        end else if (btn[1]) begin
            err_cnt_reg <= '0;
        end else if (frame_bad || timeout_hit) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    assign top_pair = err_cnt_reg;
`else
    assign top_pair = sw;
`endif

    // ---------------- Seven-segment digits ----------------
    logic [7:0][3:0] nib;
    assign nib = {top_pair, press_cnt_reg, last_reg, cur_reg};

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_seg
            localparam logic [7:0] RST_VAL = (gi < 2) ? 8'hFF : 8'h03;
            logic [7:0] seg_reg;
            // Register one digit; the scancode pair blanks when no key is held.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    seg_reg <= RST_VAL;
                end else if ((gi < 2) && !held_reg) begin
                    seg_reg <= 8'hFF;
                end else begin
                    seg_reg <= hex_font(nib[gi]);
                end
            end
        end
    endgenerate

    assign seg0 = g_seg[0].seg_reg;
    assign seg1 = g_seg[1].seg_reg;
    assign seg2 = g_seg[2].seg_reg;
    assign seg3 = g_seg[3].seg_reg;
    assign seg4 = g_seg[4].seg_reg;
    assign seg5 = g_seg[5].seg_reg;
    assign seg6 = g_seg[6].seg_reg;
    assign seg7 = g_seg[7].seg_reg;

    // ---------------- LEDs ----------------
    logic [7:0]       sw_reg;
    logic [7:0]       ring_reg;
    logic [DIV_W-1:0] div_cnt_reg;

    // Mirror switches and step the running light; btn[0] freezes the divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_reg      <= '0;
            ring_reg    <= 8'h01;
            div_cnt_reg <= '0;
        end else begin
            sw_reg <= sw;
            if (!btn[0]) begin
                if (div_cnt_reg == DIV_MAX) begin
                    div_cnt_reg <= '0;
                    ring_reg    <= {ring_reg[6:0], ring_reg[7]};
                end else begin
                    div_cnt_reg <= div_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign ledr = {ring_reg, sw_reg};

endmodule

// File: tb/tb_kbd_seg_led_panel.sv
// tb_kbd_seg_led_panel: scoreboard bench for the keyboard / 7-segment / LED
// panel. Expected outputs are queued as stimulus is driven and compared once
// the DUT has had time to respond.
module tb_kbd_seg_led_panel;

    localparam int LED_DIV     = 4;
    localparam int PS2_TIMEOUT = 200;
    localparam int HALF        = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  btn = '0;
    logic [7:0]  sw = '0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] ledr;
    logic [7:0]  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;
    logic [63:0] seg_all;

    assign seg_all = {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0};

    kbd_seg_led_panel #(
        .LED_DIV    (LED_DIV),
        .PS2_TIMEOUT(PS2_TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn),
        .sw      (sw),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .ledr    (ledr),
        .seg0    (seg0),
        .seg1    (seg1),
        .seg2    (seg2),
        .seg3    (seg3),
        .seg4    (seg4),
        .seg5    (seg5),
        .seg6    (seg6),
        .seg7    (seg7)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    string       tag_q[$];
    logic [7:0]  font [16];

    // Reference key-tracking state.
    logic [7:0] m_cur, m_last, m_cnt, m_err;
    logic       m_held, m_brk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    task automatic push(input string tag, input logic [63:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic pop_check(input logic [63:0] got);
        if (exp_q.size() == 0) begin
            check("sb_underflow", 64'(exp_q.size()), 64'd1);
        end else begin
            check(tag_q.pop_front(), got, exp_q.pop_front());
        end
    endtask

    task automatic model_reset();
        m_cur = '0; m_last = '0; m_cnt = '0; m_err = '0;
        m_held = 1'b0; m_brk = 1'b0;
    endtask

    task automatic apply_code(input logic [7:0] c);
        if (c == 8'hE0) begin
            // prefix only
        end else if (c == 8'hF0) begin
            m_brk = 1'b1;
        end else if (m_brk) begin
            m_held = 1'b0; m_brk = 1'b0; m_last = c;
        end else begin
            if (!m_held || c != m_cur) m_cnt = m_cnt + 8'd1;
            m_cur = c; m_last = c; m_held = 1'b1;
        end
    endtask

    function automatic logic [63:0] model_segs();
        logic [7:0]  top;
        logic [15:0] low;
`ifdef PS2_ERRCNT_EN
        top = m_err;
`else
        top = sw;
`endif
        low = m_held ? {font[m_cur[7:4]], font[m_cur[3:0]]} : 16'hFFFF;
        return {font[top[7:4]], font[top[3:0]], font[m_cnt[7:4]], font[m_cnt[3:0]],
                font[m_last[7:4]], font[m_last[3:0]], low};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] c, input bit bad);
        logic par;
        par = ~(^c);
        if (bad) par = ~par;
        return {1'b1, par, c, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] c, input bit bad);
        send_bits(make_frame(c, bad), 11);
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic key(input string tag, input logic [7:0] c);
        apply_code(c);
        push(tag, model_segs());
        send_frame(c, 1'b0);
        pop_check(seg_all);
    endtask

    task automatic led_step(input string tag, input logic [7:0] ring, input int cycles);
        push(tag, {48'd0, ring, 8'h00});
        repeat (cycles) @(negedge clk);
        pop_check({48'd0, ledr});
    endtask

    initial begin
        font = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                 8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
        model_reset();

        // Power-on reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        push("rst_segs", model_segs());
        push("rst_ledr", 64'h0100);
        @(negedge clk);
        pop_check(seg_all);
        pop_check({48'd0, ledr});

        // Reset in the middle of a frame; its release also times the LED test
        send_bits(make_frame(8'h1C, 1'b0), 5);
        ps2_data = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Running light, LED_DIV=4
        led_step("led_pre_step", 8'h01, 3);
        led_step("led_step1", 8'h02, 1);
        led_step("led_step2", 8'h04, 4);
        @(negedge clk);
        btn[0] = 1'b1;
        led_step("led_frozen", 8'h04, 20);
        btn[0] = 1'b0;
        led_step("led_resume", 8'h08, 3);
        led_step("led_top", 8'h80, 16);
        led_step("led_wrap", 8'h01, 4);

        // Switch mirror
        @(negedge clk);
        sw = 8'hA5;
        push("sw_not_yet", 64'h00);
        #1;
        pop_check({56'd0, ledr[7:0]});
        push("sw_mirror", 64'hA5);
        push("sw_segs", model_segs());
        @(negedge clk);
        pop_check({56'd0, ledr[7:0]});
        pop_check(seg_all);

        // Make / break
        key("make_1C", 8'h1C);
        key("brk_F0", 8'hF0);
        key("rel_1C", 8'h1C);

        // Bad parity frame is discarded
`ifdef PS2_ERRCNT_EN
        m_err = m_err + 8'd1;
`endif
        push("bad_parity", model_segs());
        send_frame(8'h1C, 1'b1);
        pop_check(seg_all);

        // Typematic repeats do not count
        key("make_1C_a", 8'h1C);
        key("rep_1C_b", 8'h1C);
        key("rep_1C_c", 8'h1C);
        key("make_32", 8'h32);

        // Clear button
        @(negedge clk);
        btn[1] = 1'b1;
        m_cnt = '0;
`ifdef PS2_ERRCNT_EN
        m_err = '0;
`endif
        push("btn1_clear", model_segs());
        @(negedge clk);
        btn[1] = 1'b0;
        repeat (3) @(negedge clk);
        pop_check(seg_all);

        // Aborted frame times out, then a clean frame decodes
        send_bits(make_frame(8'h75, 1'b0), 4);
        ps2_data = 1'b1;
`ifdef PS2_ERRCNT_EN
        m_err = m_err + 8'd1;
`endif
        push("timeout", model_segs());
        repeat (PS2_TIMEOUT + 20) @(negedge clk);
        pop_check(seg_all);
        key("prefix_E0", 8'hE0);
        key("make_75", 8'h75);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
